vga_line_fetch: RTL and testbench
=================================

// Module: vga_line_fetch
// PURPOSE
//   Pixel stage directly downstream of the VGA timing generator. Consumes pixel_x/pixel_y/blank/syncs.
//   Prefetches framebuffer line N+1 from memory into a ping-pong line buffer during line N.
//   Drives RGB332 colour plus syncs, all delayed to the same 2-cycle pipeline latency.
// PARAMETERS
//   H_ACTIVE    640    visible pixels per line
//   V_ACTIVE    480    visible lines per frame
//   V_TOTAL     521    total lines per frame (pixel_y wraps V_TOTAL-1 -> 0)
//   ADDR_W      18     memory word-address width
//   BASE_ADDR   0      word address of framebuffer line 0
//   WPL         160    words per line (H_ACTIVE/4; 4 x 8-bit pixels per 32-bit word)
// PORTS
//   clk         in   1       pixel clock
//   rst         in   1       reset, asynchronous, active-high
//   enable      in   1       1 = fetch and display framebuffer
//   pixel_x     in   10      current column from timing generator
//   pixel_y     in   10      current line from timing generator
//   blank       in   1       1 = visible region (timing-generator polarity)
//   hsync_in    in   1       active-low hsync
//   vsync_in    in   1       active-low vsync
//   mem_req     out  1       read request
//   mem_addr    out  ADDR_W  read word address
//   mem_gnt     in   1       request accepted this cycle
//   mem_rvalid  in   1       read data valid; responses return in request order
//   mem_rdata   in   32      read data; byte 0 = leftmost pixel
//   red         out  3       pixel byte[7:5]
//   green       out  3       pixel byte[4:2]
//   blue        out  2       pixel byte[1:0]
//   hsync_out   out  1       hsync_in delayed 2 cycles
//   vsync_out   out  1       vsync_in delayed 2 cycles
//   blank_out   out  1       blank delayed 2 cycles
//   underrun    out  1       sticky error flag; cleared only by rst
// BEHAVIOUR
//   Reset values:
//     - red/green/blue/blank_out/mem_req/underrun = 0; hsync_out/vsync_out = 1; mem_addr = BASE_ADDR.
//     - FSM IDLE; both bank-ready flags cleared.
//   Line buffer:
//     - Two banks of WPL x 32. Line L lives in bank L[0].
//     - Bank is ready when its fill completes; ready clears when a fill into it starts.
//   Fetch trigger:
//     - Cycle with pixel_x==H_ACTIVE (start of hblank).
//     - Target L = (pixel_y==V_TOTAL-1) ? 0 : pixel_y+1. Fetch only if L<V_ACTIVE and enable=1.
//     - Trigger while FSM not IDLE: ignored, underrun<=1.
//   FSM IDLE -> REQ -> DRAIN -> IDLE:
//     - REQ: mem_req=1 starting the cycle after trigger; mem_addr = BASE_ADDR + L*WPL + widx (mod 2^ADDR_W).
//     - widx increments on mem_gnt. mem_req/mem_addr held stable while mem_req && !mem_gnt.
//     - Grant of widx==WPL-1 -> DRAIN, mem_req=0.
//     - rvalid writes mem_rdata to bank[L[0]][rcnt], rcnt++. Allowed in REQ and DRAIN.
//     - rcnt reaching WPL -> IDLE, ready[L[0]]=1.
//     - enable falling mid-fetch: fetch completes normally.
//   Display pipeline:
//     - Cycle t: read bank[pixel_y[0]] at word pixel_x[9:2].
//     - t+1: registered RAM data; pixel_x[1:0] and control delayed.
//     - t+2: byte pixel_x[1:0] registered onto red/green/blue.
//     - Latency exactly 2 cycles for colour, syncs and blank_out.
//   Black (colour 0) when delayed blank=0, enable=0, or display bank not ready.
//   Delayed blank=1 with bank not ready and enable=1: black, underrun<=1.
//   Read and fill of the same bank never coincide by construction; no bypass required.
// CONFIGURATION
//   TEST_PATTERN_EN defined:
//     - When enable=0, visible pixels show pattern byte {pixel_x[9:6], pixel_y[8:5]}.
//     - Same 2-cycle latency; no memory traffic.
//   TEST_PATTERN_EN undefined: enable=0 gives black.
// TESTING
//   1 rst pulse mid-fetch -> outputs at reset values, mem_req=0 same cycle; no stale write after release.
//   2 pixel_y=520,x=640, gnt=1, rvalid 1 cycle after gnt:
//     -> mem_addr BASE..BASE+159 on consecutive cycles; IDLE after 160th rvalid; ready[0]=1.
//   3 Line 0 word0=32'h44332211 -> at y=0, x=0..3: colour bytes 11,22,33,44 appear 2 cycles later.
//     blank_out rises in step.
//   4 gnt low 5 cycles at widx=7 -> mem_addr held at BASE+7, mem_req held 1; resumes at BASE+8.
//   5 gnt tied 0 -> line 0 visible pixels black, underrun=1 and stays 1 until rst.
//   6 enable=0 -> no mem_req. TEST_PATTERN_EN: x=64,y=32 -> byte 8'h11.
//     Undefined: colour 0. Syncs still delayed by 2.

Source files
------------

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: ping-pong framebuffer line prefetch and RGB332 pixel pipeline.
// Optional feature macro TEST_PATTERN_EN: built-in pattern shown when enable=0.
module vga_line_fetch #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 521,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 0,
  parameter int WPL       = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              blank,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic              underrun
);

  localparam int WW = $clog2(WPL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [9:0]        line_q, line_d;
  logic [WW-1:0]     widx_q, widx_d;
  logic [WW-1:0]     rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        ready_q, ready_d;
  logic              und_q, und_d;

  logic [9:0] tgt;
  logic       fetch_go;
  logic       start;
  logic       last_gnt;
  logic       wr_en;
  logic       last_rv;

  assign tgt = (pixel_y == 10'(V_TOTAL - 1)) ? 10'd0
                                             : pixel_y + 10'd1;
  assign fetch_go = (pixel_x == 10'(H_ACTIVE)) && enable &&
                    (tgt < 10'(V_ACTIVE));
  assign start    = fetch_go && (state_q == IDLE);
  assign last_gnt = (state_q == REQ) && mem_gnt &&
                    (widx_q == WW'(WPL - 1));
  assign wr_en    = mem_rvalid &&
                    ((state_q == REQ) || (state_q == DRAIN));
  assign last_rv  = wr_en && (rcnt_q == WW'(WPL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = REQ;
      REQ: begin
        if (last_rv)       state_d = IDLE;
        else if (last_gnt) state_d = DRAIN;
      end
      DRAIN: if (last_rv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == REQ);
  end

  assign mem_addr = addr_q;

  // Display-side signals used by the underrun logic below.
  logic blank1_q, en1_q, rdy1_q;

  always_comb begin
    line_d  = line_q;
    widx_d  = widx_q;
    rcnt_d  = rcnt_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    und_d   = und_q;
    if (start) begin
      line_d  = tgt;
      widx_d  = '0;
      rcnt_d  = '0;
      addr_d  = ADDR_W'(BASE_ADDR) +
                ADDR_W'(tgt) * ADDR_W'(WPL);
      ready_d[tgt[0]] = 1'b0;
    end
    if (mem_req && mem_gnt) begin
      widx_d = widx_q + 1'b1;
      addr_d = addr_q + 1'b1;
    end
    if (wr_en) rcnt_d = rcnt_q + 1'b1;
    if (last_rv) ready_d[line_q[0]] = 1'b1;
    if (fetch_go && (state_q != IDLE)) und_d = 1'b1;
    if (blank1_q && en1_q && !rdy1_q) und_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q  <= '0;
      widx_q  <= '0;
      rcnt_q  <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      ready_q <= '0;
      und_q   <= 1'b0;
    end else begin
      line_q  <= line_d;
      widx_q  <= widx_d;
      rcnt_q  <= rcnt_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      und_q   <= und_d;
    end
  end

  assign underrun = und_q;

  logic [31:0]   lb [2][WPL];
  logic [7:0]    wx;
  logic [WW-1:0] rd_idx;
  logic [31:0]   rdata_q, rdata_d;

  // Columns past the buffer only occur in blanking; clamp to stay in range.
  assign wx     = pixel_x[9:2];
  assign rd_idx = (wx < 8'(WPL)) ? WW'(wx) : '0;

  always_comb begin
    rdata_d = lb[pixel_y[0]][rd_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en) lb[line_q[0]][rcnt_q] <= mem_rdata;
    rdata_q <= rdata_d;
  end

  logic [1:0] sel1_q, sel1_d;
  logic       blank1_d, en1_d, rdy1_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d;
  logic       blank2_q, blank2_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d;
  logic [7:0] col_q, col_d;
  logic [7:0] byte_sel;
`ifdef TEST_PATTERN_EN
  logic [7:0] pat1_q, pat1_d;
`endif

  always_comb begin
    byte_sel = rdata_q[7:0];
    unique case (sel1_q)
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
    endcase
  end

  always_comb begin
    sel1_d   = pixel_x[1:0];
    blank1_d = blank;
    hs1_d    = hsync_in;
    vs1_d    = vsync_in;
    en1_d    = enable;
    rdy1_d   = ready_q[pixel_y[0]];
`ifdef TEST_PATTERN_EN
    pat1_d   = {pixel_x[9:6], pixel_y[8:5]};
`endif
    blank2_d = blank1_q;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    col_d    = '0;
    if (blank1_q) begin
      if (en1_q) begin
        if (rdy1_q) col_d = byte_sel;
      end
`ifdef TEST_PATTERN_EN
      else col_d = pat1_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel1_q   <= '0;
      blank1_q <= 1'b0;
      en1_q    <= 1'b0;
      rdy1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      blank2_q <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      col_q    <= '0;
`ifdef TEST_PATTERN_EN
      pat1_q   <= '0;
`endif
    end else begin
      sel1_q   <= sel1_d;
      blank1_q <= blank1_d;
      en1_q    <= en1_d;
      rdy1_q   <= rdy1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      blank2_q <= blank2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      col_q    <= col_d;
`ifdef TEST_PATTERN_EN
      pat1_q   <= pat1_d;
`endif
    end
  end

  assign red       = col_q[7:5];
  assign green     = col_q[4:2];
  assign blue      = col_q[1:0];
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign blank_out = blank2_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed scenario tests for the line-fetch pixel stage.
// Memory responder returns 32'h44332211 + addr*32'h01010101 one cycle after grant.
module tb_vga_line_fetch;

  logic        clk, rst, enable;
  logic [9:0]  pixel_x, pixel_y;
  logic        blank, hsync_in, vsync_in;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [17:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        hsync_out, vsync_out, blank_out, underrun;

  int total = 0;
  int bad   = 0;

  vga_line_fetch dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .blank(blank), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .blank_out(blank_out), .underrun(underrun)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  logic        rsp_f;
  logic [17:0] rsp_a;
  initial begin
    mem_rvalid = 0;
    mem_rdata  = 0;
    forever begin
      @(negedge clk);
      rsp_f = mem_req && mem_gnt;
      rsp_a = mem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = rsp_f;
      mem_rdata  = 32'h44332211 + 32'(rsp_a) * 32'h01010101;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic b,
                       input logic hs, input logic vs);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    blank    = b;
    hsync_in = hs;
    vsync_in = vs;
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; mem_gnt = 0;
    drive(0, 0, 0, 0, 0);
    step(); step();
    total++;
    if ({red, green, blue, blank_out, mem_req, underrun} !== 11'b0) begin
      bad++;
      $display("FAIL reset_zero got=%b want=0",
               {red, green, blue, blank_out, mem_req, underrun});
    end
    total++;
    if ({hsync_out, vsync_out} !== 2'b11) begin
      bad++;
      $display("FAIL reset_sync got=%b want=11", {hsync_out, vsync_out});
    end
    total++;
    if (mem_addr !== 18'd0) begin
      bad++;
      $display("FAIL reset_addr got=%h want=0", mem_addr);
    end
    rst = 0;
    drive(0, 0, 0, 1, 1);
    step(); step();
  endtask

  task automatic test_fetch_line0();
    enable = 1; mem_gnt = 1;
    drive(640, 520, 0, 1, 1);
    step();
    pixel_x = 10'd641;
    for (int k = 0; k < 160; k++) begin
      total++;
      if ({mem_req, mem_addr} !== {1'b1, 18'(k)}) begin
        bad++;
        $display("FAIL fetch_addr k=%0d got=%b/%h want=1/%h",
                 k, mem_req, mem_addr, 18'(k));
      end
      step();
    end
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fetch_drain_req got=%b want=0", mem_req);
    end
    for (int k = 0; k < 10 && dut.ready_q[0] !== 1'b1; k++) step();
    total++;
    if (dut.ready_q[0] !== 1'b1 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fetch_ready got=%b req=%b want=1/0",
               dut.ready_q[0], mem_req);
    end
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL fetch_underrun got=%b want=0", underrun);
    end
    mem_gnt = 0;
  endtask

  localparam int   DX  [8] = '{798, 799, 0, 1, 2, 3, 4, 5};
  localparam int   DY  [8] = '{520, 520, 0, 0, 0, 0, 0, 0};
  localparam logic DB  [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
  localparam logic DHS [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
  localparam logic DVS [8] = '{0, 1, 1, 1, 0, 1, 1, 0};
  localparam logic [7:0] DC [8] =
    '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h12, 8'h23};

  task automatic test_display();
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        total++;
        if ({red, green, blue} !== DC[i-2]) begin
          bad++;
          $display("FAIL disp_colour i=%0d got=%h want=%h",
                   i - 2, {red, green, blue}, DC[i-2]);
        end
        total++;
        if ({blank_out, hsync_out, vsync_out} !==
            {DB[i-2], DHS[i-2], DVS[i-2]}) begin
          bad++;
          $display("FAIL disp_ctrl i=%0d got=%b want=%b",
                   i - 2, {blank_out, hsync_out, vsync_out},
                   {DB[i-2], DHS[i-2], DVS[i-2]});
        end
      end
      if (i < 8) drive(DX[i], DY[i], DB[i], DHS[i], DVS[i]);
      step();
    end
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL disp_underrun got=%b want=0", underrun);
    end
  endtask

  task automatic test_gnt_stall();
    int e;
    mem_gnt = 1;
    drive(640, 0, 0, 1, 1);
    step();
    pixel_x = 10'd641;
    for (int n = 0; n <= 20; n++) begin
      e = (n <= 7) ? 160 + n : (n <= 12) ? 167 : 155 + n;
      total++;
      if ({mem_req, mem_addr} !== {1'b1, 18'(e)}) begin
        bad++;
        $display("FAIL stall_addr n=%0d got=%b/%h want=1/%h",
                 n, mem_req, mem_addr, 18'(e));
      end
      mem_gnt = (n >= 7 && n < 12) ? 1'b0 : 1'b1;
      step();
    end
    for (int k = 0; k < 300 && dut.ready_q[1] !== 1'b1; k++) step();
    total++;
    if (dut.ready_q[1] !== 1'b1 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL stall_done ready1=%b und=%b want=1/0",
               dut.ready_q[1], underrun);
    end
    mem_gnt = 0;
  endtask

  task automatic test_no_grant();
    mem_gnt = 0;
    drive(640, 520, 0, 1, 1);
    step();
    pixel_x = 10'd641;
    step(); step();
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        total++;
        if ({red, green, blue, blank_out} !== 9'b0_0000_0001) begin
          bad++;
          $display("FAIL nognt_black i=%0d got=%h/%b want=00/1",
                   i - 2, {red, green, blue}, blank_out);
        end
      end
      if (i < 4) drive(i, 0, 1, 1, 1);
      step();
    end
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL nognt_underrun got=%b want=1", underrun);
    end
    drive(700, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) step();
    total++;
    if ({underrun, mem_req, mem_addr} !== {1'b1, 1'b1, 18'd0}) begin
      bad++;
      $display("FAIL nognt_sticky got=%b/%b/%h want=1/1/0",
               underrun, mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    mem_gnt = 1;
    for (int i = 0; i < 30; i++) step();
    hsync_in = 0; vsync_in = 0;
    rst = 1;
    #1;
    total++;
    if ({mem_req, underrun, mem_addr} !== 20'd0) begin
      bad++;
      $display("FAIL rstmid_now got=%b/%b/%h want=0/0/0",
               mem_req, underrun, mem_addr);
    end
    step();
    total++;
    if ({red, green, blue, blank_out, hsync_out, vsync_out} !==
        11'b00000000_0_11) begin
      bad++;
      $display("FAIL rstmid_out got=%b want=00000000011",
               {red, green, blue, blank_out, hsync_out, vsync_out});
    end
    step();
    rst = 0;
    hsync_in = 1; vsync_in = 1;
    for (int i = 0; i < 5; i++) step();
    total++;
    if ({mem_req, dut.ready_q} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_after got=%b want=000", {mem_req, dut.ready_q});
    end
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        total++;
        if ({red, green, blue} !== 8'h00) begin
          bad++;
          $display("FAIL rstmid_black i=%0d got=%h want=00",
                   i - 2, {red, green, blue});
        end
      end
      if (i < 4) drive(i, 0, 1, 1, 1);
      step();
    end
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_stale got=%b want=1", underrun);
    end
  endtask

  task automatic test_enable_off();
    logic [7:0] pc;
`ifdef TEST_PATTERN_EN
    pc = 8'h11;
`else
    pc = 8'h00;
`endif
    rst = 1;
    step();
    rst = 0;
    enable = 0; mem_gnt = 1;
    drive(640, 520, 0, 1, 1);
    step();
    pixel_x = 10'd641;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mem_req !== 1'b0) begin
        bad++;
        $display("FAIL en0_req i=%0d got=%b want=0", i, mem_req);
      end
      step();
    end
    drive(64, 32, 1, 0, 1);
    step();
    drive(65, 32, 1, 1, 0);
    step();
    drive(66, 32, 0, 1, 1);
    total++;
    if ({red, green, blue, blank_out, hsync_out, vsync_out} !==
        {pc, 3'b101}) begin
      bad++;
      $display("FAIL en0_px0 got=%h/%b want=%h/101",
               {red, green, blue}, {blank_out, hsync_out, vsync_out}, pc);
    end
    step();
    total++;
    if ({red, green, blue, blank_out, hsync_out, vsync_out} !==
        {pc, 3'b110}) begin
      bad++;
      $display("FAIL en0_px1 got=%h/%b want=%h/110",
               {red, green, blue}, {blank_out, hsync_out, vsync_out}, pc);
    end
    step();
    total++;
    if ({red, green, blue, blank_out, hsync_out, vsync_out, underrun} !==
        12'b00000000_011_0) begin
      bad++;
      $display("FAIL en0_px2 got=%b want=000000000110",
               {red, green, blue, blank_out, hsync_out, vsync_out, underrun});
    end
  endtask

  initial begin
    test_reset();
    test_fetch_line0();
    test_display();
    test_gnt_stall();
    test_no_grant();
    test_reset_mid_fetch();
    test_enable_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
